// File: rtl/ifu_fetch.sv
// Instruction-fetch stage: owns the PC, issues one instruction-memory read at a time,
// and presents the captured instruction to decode as {PC, Instr, PC_4, diffen}.
module ifu_fetch #(
   parameter int                  PC_WIDTH        = 32,
   parameter int                  DATA_WIDTH      = 32,
   parameter logic [PC_WIDTH-1:0] RESET_PC        = 32'h8000_0000,
   parameter int                  IF_ID_BUS_WIDTH = 2*PC_WIDTH+DATA_WIDTH+1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       if_id_reg_enable,
   input  logic                       bpu_clear_ctrl,
   input  logic [PC_WIDTH-1:0]        redirect_pc,
   output logic                       imem_req_valid,
   input  logic                       imem_req_ready,
   output logic [PC_WIDTH-1:0]        imem_req_addr,
   input  logic                       imem_resp_valid,
   input  logic [DATA_WIDTH-1:0]      imem_resp_data,
   output logic [IF_ID_BUS_WIDTH-1:0] if_id_bus,
   output logic                       fetch_busy
);

   typedef enum logic [1:0] {
      ST_REQ  = 2'd0,
      ST_WAIT = 2'd1,
      ST_HOLD = 2'd2,
      ST_DROP = 2'd3
   } state_t;

   state_t                state_r;
   state_t                state_s;
   logic [PC_WIDTH-1:0]   pc_r;
   logic [DATA_WIDTH-1:0] instr_r;
   logic [PC_WIDTH-1:0]   pc_plus4_s;
   logic [PC_WIDTH-1:0]   redirect_aligned_s;
   logic                  handshake_s;

   assign pc_plus4_s         = pc_r + PC_WIDTH'(4);
   assign redirect_aligned_s = redirect_pc & ~PC_WIDTH'(3);
   assign handshake_s        = (state_r == ST_REQ) && imem_req_ready;

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_REQ;
      end else begin
         state_r <= state_s;
      end
   end

   // FSM next-state logic; redirect outranks every other event
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_REQ: begin
            if (handshake_s) begin
               state_s = bpu_clear_ctrl ? ST_DROP : ST_WAIT;
            end else begin
               state_s = ST_REQ;
            end
         end
         ST_WAIT: begin
            if (bpu_clear_ctrl) begin
               state_s = imem_resp_valid ? ST_REQ : ST_DROP;
            end else if (imem_resp_valid) begin
               state_s = ST_HOLD;
            end else begin
               state_s = ST_WAIT;
            end
         end
         ST_HOLD: begin
            if (bpu_clear_ctrl || if_id_reg_enable) begin
               state_s = ST_REQ;
            end else begin
               state_s = ST_HOLD;
            end
         end
         // a redirect while draining only retargets pc; the drain still ends on the response
         ST_DROP: begin
            if (imem_resp_valid) begin
               state_s = ST_REQ;
            end else begin
               state_s = ST_DROP;
            end
         end
         default: state_s = ST_REQ;
      endcase
   end

   // PC and instruction registers
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_r    <= RESET_PC;
         instr_r <= '0;
      end else begin
         if (bpu_clear_ctrl) begin
            pc_r <= redirect_aligned_s;
         end else if ((state_r == ST_HOLD) && if_id_reg_enable) begin
            pc_r <= pc_plus4_s;
         end
         // responses outside WAIT are protocol errors and leave instr untouched
         if ((state_r == ST_WAIT) && imem_resp_valid && !bpu_clear_ctrl) begin
            instr_r <= imem_resp_data;
         end
      end
   end

   // FSM outputs, decoded from the registered state only
   always_comb begin
      imem_req_valid = 1'b0;
      fetch_busy     = 1'b0;
      if_id_bus      = '0;
      case (state_r)
         ST_REQ:  imem_req_valid = 1'b1;
         ST_WAIT: fetch_busy     = 1'b1;
         ST_HOLD: if_id_bus      = {pc_r, instr_r, pc_plus4_s, 1'b1};
         ST_DROP: fetch_busy     = 1'b1;
         default: imem_req_valid = 1'b0;
      endcase
   end

   assign imem_req_addr = pc_r;

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: directed scenarios plus randomized traffic
// compared against a transaction-level model of the fetch stage.
module tb_ifu_fetch;

   localparam logic [31:0] RST_PC = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        if_id_reg_enable = 1'b0;
   logic        bpu_clear_ctrl = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b0;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid = 1'b0;
   logic [31:0] imem_resp_data = 32'h0;
   logic [96:0] if_id_bus;
   logic        fetch_busy;

   int tests = 0;
   int fails = 0;

   ifu_fetch dut (
      .clk(clk), .rst(rst),
      .if_id_reg_enable(if_id_reg_enable),
      .bpu_clear_ctrl(bpu_clear_ctrl),
      .redirect_pc(redirect_pc),
      .imem_req_valid(imem_req_valid),
      .imem_req_ready(imem_req_ready),
      .imem_req_addr(imem_req_addr),
      .imem_resp_valid(imem_resp_valid),
      .imem_resp_data(imem_resp_data),
      .if_id_bus(if_id_bus),
      .fetch_busy(fetch_busy)
   );

   always #5 clk = ~clk;

   // Drive one cycle of inputs, let the edge happen, sample 1 time unit later.
   task automatic tick(input logic rs, input logic rdy, input logic en, input logic clr,
                       input logic [31:0] rpc, input logic rv, input logic [31:0] rd);
      rst = rs; imem_req_ready = rdy; if_id_reg_enable = en; bpu_clear_ctrl = clr;
      redirect_pc = rpc; imem_resp_valid = rv; imem_resp_data = rd;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      tick(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      tests++;
      if ({imem_req_valid, imem_req_addr, fetch_busy, if_id_bus} !== {1'b1, RST_PC, 1'b0, 97'h0}) begin
         fails++;
         $display("FAIL reset: valid=%b addr=%h busy=%b bus=%h, expected 1 %h 0 0",
                  imem_req_valid, imem_req_addr, fetch_busy, if_id_bus, RST_PC);
      end
   endtask

   task automatic test_basic_fetch();
      tick(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      tests++;
      if ({imem_req_valid, fetch_busy, if_id_bus} !== {1'b0, 1'b1, 97'h0}) begin
         fails++;
         $display("FAIL basic_wait: valid=%b busy=%b bus=%h, expected 0 1 0", imem_req_valid, fetch_busy, if_id_bus);
      end
      tick(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0013);
      tests++;
      if (if_id_bus !== {RST_PC, 32'h0000_0013, 32'h8000_0004, 1'b1}) begin
         fails++;
         $display("FAIL basic_bus: got %h expected %h", if_id_bus, {RST_PC, 32'h0000_0013, 32'h8000_0004, 1'b1});
      end
      tick(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      tests++;
      if ({imem_req_valid, imem_req_addr, if_id_bus} !== {1'b1, 32'h8000_0004, 97'h0}) begin
         fails++;
         $display("FAIL basic_next: valid=%b addr=%h bus=%h, expected 1 80000004 0", imem_req_valid, imem_req_addr, if_id_bus);
      end
   endtask

   task automatic test_backpressure();
      tick(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      for (int i = 0; i < 4; i++) begin
         tick(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
         tests++;
         if ({imem_req_valid, imem_req_addr, fetch_busy} !== {1'b1, RST_PC, 1'b0}) begin
            fails++;
            $display("FAIL backpressure_hold[%0d]: valid=%b addr=%h busy=%b, expected 1 %h 0",
                     i, imem_req_valid, imem_req_addr, fetch_busy, RST_PC);
         end
      end
      tick(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      tests++;
      if ({imem_req_valid, fetch_busy} !== 2'b01) begin
         fails++;
         $display("FAIL backpressure_wait: valid=%b busy=%b, expected 0 1", imem_req_valid, fetch_busy);
      end
   endtask

   task automatic test_stall();
      logic [96:0] exp_bus;
      exp_bus = {RST_PC, 32'h1234_5678, 32'h8000_0004, 1'b1};
      tick(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h1234_5678);
      for (int i = 0; i < 3; i++) begin
         tick(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
         tests++;
         if ({imem_req_valid, if_id_bus} !== {1'b0, exp_bus}) begin
            fails++;
            $display("FAIL stall_hold[%0d]: valid=%b bus=%h expected 0 %h", i, imem_req_valid, if_id_bus, exp_bus);
         end
      end
      tick(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      tests++;
      if ({imem_req_valid, imem_req_addr, if_id_bus} !== {1'b1, 32'h8000_0004, 97'h0}) begin
         fails++;
         $display("FAIL stall_release: valid=%b addr=%h bus=%h expected 1 80000004 0", imem_req_valid, imem_req_addr, if_id_bus);
      end
   endtask

   task automatic test_redirect_wait();
      tick(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      tick(1'b0, 1'b0, 1'b0, 1'b1, 32'h8000_0100, 1'b0, 32'h0);
      tests++;
      if ({imem_req_valid, fetch_busy, if_id_bus} !== {1'b0, 1'b1, 97'h0}) begin
         fails++;
         $display("FAIL redirect_wait_drop: valid=%b busy=%b bus=%h expected 0 1 0", imem_req_valid, fetch_busy, if_id_bus);
      end
      tick(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF);
      tests++;
      if ({imem_req_valid, imem_req_addr, fetch_busy, if_id_bus} !== {1'b1, 32'h8000_0100, 1'b0, 97'h0}) begin
         fails++;
         $display("FAIL redirect_wait_req: valid=%b addr=%h busy=%b bus=%h expected 1 80000100 0 0",
                  imem_req_valid, imem_req_addr, fetch_busy, if_id_bus);
      end
   endtask

   task automatic test_redirect_hold();
      tick(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      tick(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hCAFE_0001);
      tests++;
      if (if_id_bus !== {32'h8000_0100, 32'hCAFE_0001, 32'h8000_0104, 1'b1}) begin
         fails++;
         $display("FAIL redirect_hold_bus: got %h", if_id_bus);
      end
      tick(1'b0, 1'b0, 1'b1, 1'b1, 32'h8000_0203, 1'b0, 32'h0);
      tests++;
      if ({imem_req_valid, imem_req_addr, if_id_bus} !== {1'b1, 32'h8000_0200, 97'h0}) begin
         fails++;
         $display("FAIL redirect_hold: valid=%b addr=%h bus=%h expected 1 80000200 0", imem_req_valid, imem_req_addr, if_id_bus);
      end
   endtask

   task automatic test_wrap();
      tick(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0);
      tests++;
      if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'hFFFF_FFFC}) begin
         fails++;
         $display("FAIL redirect_req: valid=%b addr=%h expected 1 fffffffc", imem_req_valid, imem_req_addr);
      end
      tick(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      tick(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0073);
      tests++;
      if (if_id_bus !== {32'hFFFF_FFFC, 32'h0000_0073, 32'h0000_0000, 1'b1}) begin
         fails++;
         $display("FAIL wrap_bus: got %h expected %h", if_id_bus, {32'hFFFF_FFFC, 32'h0000_0073, 32'h0, 1'b1});
      end
      tick(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      tests++;
      if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h0}) begin
         fails++;
         $display("FAIL wrap_next: valid=%b addr=%h expected 1 00000000", imem_req_valid, imem_req_addr);
      end
   endtask

   task automatic test_reset_mid();
      tick(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      tick(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      tests++;
      if ({imem_req_valid, imem_req_addr, fetch_busy, if_id_bus} !== {1'b1, RST_PC, 1'b0, 97'h0}) begin
         fails++;
         $display("FAIL reset_mid: valid=%b addr=%h busy=%b bus=%h expected 1 %h 0 0",
                  imem_req_valid, imem_req_addr, fetch_busy, if_id_bus, RST_PC);
      end
   endtask

   // Model: "in flight" / "holding an instruction" / "flush pending" flags per the fetch rules.
   task automatic test_random();
      logic [31:0] m_pc, m_instr;
      bit m_out, m_have, m_disc, mem_pend, hs;
      int mem_delay;
      logic rs, rdy, en, clr, rv;
      logic [31:0] rpc, rd;
      logic [96:0] exp_bus;
      tick(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      m_pc = RST_PC; m_instr = 32'h0; m_out = 0; m_have = 0; m_disc = 0; mem_pend = 0; mem_delay = 0;
      for (int c = 0; c < 3000; c++) begin
         exp_bus = m_have ? {m_pc, m_instr, m_pc + 32'd4, 1'b1} : 97'h0;
         tests++;
         if ({imem_req_valid, imem_req_addr, fetch_busy, if_id_bus} !== {(!m_out && !m_have), m_pc, m_out, exp_bus}) begin
            fails++;
            $display("FAIL random[%0d]: valid=%b addr=%h busy=%b bus=%h expected %b %h %b %h", c,
                     imem_req_valid, imem_req_addr, fetch_busy, if_id_bus, (!m_out && !m_have), m_pc, m_out, exp_bus);
         end
         rs  = ($urandom_range(0, 199) == 0);
         rdy = ($urandom_range(0, 2) != 0);
         en  = ($urandom_range(0, 3) != 0);
         clr = ($urandom_range(0, 9) == 0);
         rpc = $urandom;
         rd  = $urandom;
         if (mem_pend && mem_delay == 0) rv = 1'b1;
         else if (!mem_pend) rv = ($urandom_range(0, 19) == 0);
         else rv = 1'b0;
         hs = !m_out && !m_have && rdy;
         if (mem_pend) begin
            if (mem_delay == 0) mem_pend = 0;
            else mem_delay--;
         end
         if (rs) begin
            mem_pend = 0;
            m_pc = RST_PC; m_instr = 32'h0; m_out = 0; m_have = 0; m_disc = 0;
         end else begin
            if (hs) begin
               mem_pend = 1;
               mem_delay = $urandom_range(0, 2);
            end
            if (m_have) begin
               if (clr || en) m_have = 0;
               if (!clr && en) m_pc = m_pc + 32'd4;
            end else if (!m_out) begin
               if (hs) begin
                  m_out = 1; m_disc = clr;
               end
            end else if (rv) begin
               m_out = 0;
               if (!m_disc && !clr) begin
                  m_have = 1; m_instr = rd;
               end
            end else if (clr) begin
               m_disc = 1;
            end
            if (clr) m_pc = rpc & 32'hFFFF_FFFC;
         end
         tick(rs, rdy, en, clr, rpc, rv, rd);
      end
   endtask

   initial begin
      test_reset();
      test_basic_fetch();
      test_backpressure();
      test_stall();
      test_redirect_wait();
      test_redirect_hold();
      test_wrap();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
